mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, memory byte-address width.
REQ-002 SHALL have parameter STARVE_MAX, default 4, consecutive denied fetch cycles before fetch is forced.
REQ-003 SHALL have port clk  in  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port nreset  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port clk_en  in  1  global enable; low freezes all state.
REQ-006 SHALL have ports if_req in 1, if_addr in 32; if_gnt out 1, if_rdata out 32, if_rvalid out 1: instruction-fetch read port.
REQ-007 SHALL have ports d_req in 1, d_we in 1, d_addr in 32, d_wdata in 32; d_gnt out 1, d_rdata out 32, d_rvalid out 1: data read/write port.
REQ-008 SHALL have ports mem_en out 1, mem_we out 1, mem_addr out ADDR_W, mem_wdata out 32, mem_rdata in 32: single-port memory, 32-bit little-endian words, read data valid one cycle after mem_en.
REQ-009 SHALL have port err_misalign  out  1  sticky flag, misaligned request seen.

Function
REQ-010 Grant SHALL be combinational: at most one of if_gnt/d_gnt high per cycle, only while clk_en=1 and the matching req=1.
REQ-011 Default priority SHALL be data over fetch.
REQ-012 mem_en SHALL equal (if_gnt|d_gnt) for aligned requests; mem_we=d_gnt&d_we; mem_addr=granted addr[ADDR_W-1:0]; mem_wdata=d_wdata.
REQ-013 A granted read SHALL produce the owner's rvalid exactly one enabled cycle later, with rdata=mem_rdata; a write SHALL produce no rvalid.
REQ-014 Owner of the outstanding read SHALL be held in a registered state: IDLE, IF_PEND, D_PEND; next state from the grant of the current cycle, IDLE when none.
REQ-015 Back-to-back grants SHALL be allowed: a new grant may issue in the same cycle a previous read's rvalid is asserted.
REQ-016 rdata on the non-owner port SHALL hold its last value; rvalid is a one-cycle pulse.
REQ-017 Request with addr[1:0]!=0 SHALL be granted (consumed), SHALL NOT drive mem_en, SHALL return no rvalid, and SHALL set err_misalign.
REQ-018 Address bits above ADDR_W-1 SHALL be ignored (wrap-around modulo 2**ADDR_W).
REQ-019 clk_en=0 SHALL force gnt=0, mem_en=0, and hold state, counter, rvalid registers unchanged.

Reset
REQ-020 While nreset=0 at a rising edge: state=IDLE, if_rvalid=0, d_rvalid=0, if_rdata=0, d_rdata=0, err_misalign=0, starvation counter=0.
REQ-021 Reset during an outstanding read SHALL discard it; no rvalid after reset release.
REQ-022 Grants SHALL be suppressed in any cycle where nreset=0.

Configuration
REQ-023 With MEM_ARB_STARVE_GUARD_EN defined: counter increments each enabled cycle fetch is requested but denied, saturating at STARVE_MAX; at STARVE_MAX fetch wins over data for one grant, then counter clears.
REQ-024 Without MEM_ARB_STARVE_GUARD_EN: fixed data priority, no counter logic; STARVE_MAX unused.

Structure
REQ-025 Shared package mem_arb_pkg SHALL hold the state enum (IDLE, IF_PEND, D_PEND) and the word-width constant 32.
REQ-026 Sub-module mem_arb_starve (counter and force flag) SHALL be the only sub-module, instantiated only under MEM_ARB_STARVE_GUARD_EN.

Verification
REQ-027 Fetch only, if_addr=0x10, mem word 0xC8000000 -> if_gnt same cycle, if_rvalid next cycle, if_rdata=0xC8000000.
REQ-028 Simultaneous if_req (0x0) and d_req read (0x100) -> d_gnt first, d_rvalid next cycle; if_gnt following cycle; no overlapping grants.
REQ-029 d_req write 0xDEADBEEF to 0x20, then fetch 0x20 -> mem_we pulse once, if_rdata=0xDEADBEEF, no d_rvalid.
REQ-030 Guard enabled, STARVE_MAX=4, d_req and if_req held high -> four d_gnt cycles, then one if_gnt, pattern repeats; guard disabled -> if_gnt never.
REQ-031 d_addr=0x102 read -> d_gnt=1, mem_en=0, no d_rvalid, err_misalign=1 until reset.
REQ-032 nreset low in the cycle after a fetch grant -> no if_rvalid; clk_en low for 3 cycles mid-read -> if_rvalid delayed to first enabled cycle.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory arbiter: word width and read-owner state encoding.
package mem_arb_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_PEND = 2'd1,
    D_PEND  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side bundle of the arbiter; slave modport is the arbiter, master is its environment.
// Handshake: a req is consumed in the same cycle its gnt is high; a read's rvalid pulses one enabled cycle later.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16
);
  logic              if_req;
  logic [31:0]       if_addr;
  logic              if_gnt;
  logic [31:0]       if_rdata;
  logic              if_rvalid;

  logic              d_req;
  logic              d_we;
  logic [31:0]       d_addr;
  logic [31:0]       d_wdata;
  logic              d_gnt;
  logic [31:0]       d_rdata;
  logic              d_rvalid;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rdata, if_rvalid, d_gnt, d_rdata, d_rvalid,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rdata, if_rvalid, d_gnt, d_rdata, d_rvalid,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arb_starve.sv
// Fetch starvation guard: counts denied fetch cycles and raises force_if once STARVE_MAX is reached.
module mem_arb_starve #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic nreset,
  input  logic clk_en,
  input  logic if_req,
  input  logic if_gnt,
  output logic force_if
);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      cnt <= '0;
    end else if (clk_en) begin
      if (if_gnt) begin
        cnt <= '0;
      end else if (if_req && cnt != CNT_MAX) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign force_if = (cnt == CNT_MAX);
endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single-port synchronous memory, data has priority.
// Define MEM_ARB_STARVE_GUARD_EN to let fetch win one grant after STARVE_MAX denied cycles.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                nreset,
  input  logic                clk_en,
  mem_arbiter_if.slave        bus,
  output logic                err_misalign,
  output arb_state_t          state_dbg
);
  logic              enabled;
  logic              force_if;
  logic              if_gnt;
  logic              d_gnt;
  logic              any_gnt;
  logic              aligned;
  logic              if_rvalid;
  logic              d_rvalid;
  logic [WORD_W-1:0] gaddr;
  logic [WORD_W-1:0] if_rdata_q;
  logic [WORD_W-1:0] d_rdata_q;
  logic              unused_addr_hi;
  arb_state_t        state;

  if (STARVE_MAX < 1) begin : g_starve_max_must_be_positive
  end

`ifdef MEM_ARB_STARVE_GUARD_EN
  mem_arb_starve #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk     (clk),
    .nreset  (nreset),
    .clk_en  (clk_en),
    .if_req  (bus.if_req),
    .if_gnt  (if_gnt),
    .force_if(force_if)
  );
`else
  assign force_if = 1'b0;
`endif

  // force_if comes from a register, so grants stay free of combinational loops.
  assign enabled = clk_en & nreset;
  assign d_gnt   = enabled & bus.d_req & ~(force_if & bus.if_req);
  assign if_gnt  = enabled & bus.if_req & (~bus.d_req | force_if);
  assign any_gnt = if_gnt | d_gnt;

  assign gaddr          = d_gnt ? bus.d_addr : bus.if_addr;
  assign aligned        = (gaddr[1:0] == 2'b00);
  assign unused_addr_hi = ^gaddr[WORD_W-1:ADDR_W];

  assign bus.if_gnt    = if_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.mem_en    = any_gnt & aligned;
  assign bus.mem_we    = d_gnt & bus.d_we & aligned;
  assign bus.mem_addr  = gaddr[ADDR_W-1:0];
  assign bus.mem_wdata = bus.d_wdata;

  // Memory data is only present in the cycle after the access, so the owner
  // sees mem_rdata directly then and a held copy afterwards.
  assign if_rvalid     = enabled & (state == IF_PEND);
  assign d_rvalid      = enabled & (state == D_PEND);
  assign bus.if_rvalid = if_rvalid;
  assign bus.d_rvalid  = d_rvalid;
  assign bus.if_rdata  = if_rvalid ? bus.mem_rdata : if_rdata_q;
  assign bus.d_rdata   = d_rvalid ? bus.mem_rdata : d_rdata_q;
  assign state_dbg     = state;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state        <= IDLE;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      err_misalign <= 1'b0;
    end else if (clk_en) begin
      if (if_rvalid) if_rdata_q <= bus.mem_rdata;
      if (d_rvalid)  d_rdata_q  <= bus.mem_rdata;
      if (any_gnt && !aligned) err_misalign <= 1'b1;
      if (if_gnt && aligned) begin
        state <= IF_PEND;
      end else if (d_gnt && aligned && !bus.d_we) begin
        state <= D_PEND;
      end else begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural synchronous memory.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic       clk;
  logic       nreset;
  logic       clk_en;
  logic       err_misalign;
  arb_state_t state_dbg;

  int n_total = 0;
  int n_pass  = 0;
  int we_cnt  = 0;
  int we_base;
  logic [1:0] exp_gnt;

  logic [31:0] mem [0:(1<<14)-1];

  mem_arbiter_if #(.ADDR_W(16)) bus ();

  mem_arbiter #(
    .ADDR_W    (16),
    .STARVE_MAX(4)
  ) dut (
    .clk         (clk),
    .nreset      (nreset),
    .clk_en      (clk_en),
    .bus         (bus),
    .err_misalign(err_misalign),
    .state_dbg   (state_dbg)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous single-port memory: read data appears the cycle after mem_en
  always @(posedge clk) begin
    if (bus.mem_en === 1'b1) begin
      if (bus.mem_we === 1'b1) mem[bus.mem_addr[15:2]] = bus.mem_wdata;
      else bus.mem_rdata <= mem[bus.mem_addr[15:2]];
    end
  end

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) we_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_req  = 1'b0;
    bus.if_addr = 32'h0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = 32'h0;
    bus.d_wdata = 32'h0;
  endtask

  task automatic fetch(input logic [31:0] addr);
    bus.if_req  = 1'b1;
    bus.if_addr = addr;
  endtask

  task automatic data(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    bus.d_req   = 1'b1;
    bus.d_we    = we;
    bus.d_addr  = addr;
    bus.d_wdata = wdata;
  endtask

  initial begin
    mem[32'h10  >> 2] = 32'hC800_0000;
    mem[32'h100 >> 2] = 32'h1122_3344;
    mem[32'h0   >> 2] = 32'hA5A5_0000;
    mem[32'h20  >> 2] = 32'h0;
    bus.mem_rdata = 32'h0;
    idle_inputs();
    nreset = 1'b0;
    clk_en = 1'b1;
    fetch(32'h10);

    // reset state; grants suppressed while nreset is low
    tick(); tick();
    check("rst_if_gnt",   {31'b0, bus.if_gnt},    32'h0);
    check("rst_mem_en",   {31'b0, bus.mem_en},    32'h0);
    check("rst_if_rvalid",{31'b0, bus.if_rvalid}, 32'h0);
    check("rst_d_rvalid", {31'b0, bus.d_rvalid},  32'h0);
    check("rst_if_rdata", bus.if_rdata,           32'h0);
    check("rst_d_rdata",  bus.d_rdata,            32'h0);
    check("rst_err",      {31'b0, err_misalign},  32'h0);
    check("rst_state",    32'(state_dbg),         32'(IDLE));
    idle_inputs();
    nreset = 1'b1;

    // fetch only from 0x10
    tick();
    fetch(32'h10); #1;
    check("f_if_gnt",   {31'b0, bus.if_gnt}, 32'h1);
    check("f_d_gnt",    {31'b0, bus.d_gnt},  32'h0);
    check("f_mem_en",   {31'b0, bus.mem_en}, 32'h1);
    check("f_mem_addr", 32'(bus.mem_addr),   32'h10);
    tick();
    idle_inputs(); #1;
    check("f_state",     32'(state_dbg),         32'(IF_PEND));
    check("f_if_rvalid", {31'b0, bus.if_rvalid}, 32'h1);
    check("f_if_rdata",  bus.if_rdata,           32'hC800_0000);
    tick();
    check("f_rvalid_pulse", {31'b0, bus.if_rvalid}, 32'h0);
    check("f_rdata_hold",   bus.if_rdata,           32'hC800_0000);

    // simultaneous fetch 0x0 and data read 0x100
    fetch(32'h0);
    data(1'b0, 32'h100, 32'h0); #1;
    check("sim_gnt0",     {30'b0, bus.if_gnt, bus.d_gnt}, 32'h1);
    check("sim_addr0",    32'(bus.mem_addr),              32'h100);
    tick();
    bus.d_req = 1'b0; #1;
    check("sim_d_rvalid", {31'b0, bus.d_rvalid},          32'h1);
    check("sim_d_rdata",  bus.d_rdata,                    32'h1122_3344);
    check("sim_gnt1",     {30'b0, bus.if_gnt, bus.d_gnt}, 32'h2);
    check("sim_addr1",    32'(bus.mem_addr),              32'h0);
    tick();
    idle_inputs(); #1;
    check("sim_if_rvalid", {31'b0, bus.if_rvalid}, 32'h1);
    check("sim_if_rdata",  bus.if_rdata,           32'hA5A5_0000);
    check("sim_d_rvalid1", {31'b0, bus.d_rvalid},  32'h0);
    check("sim_d_hold",    bus.d_rdata,            32'h1122_3344);

    // write 0xDEADBEEF to 0x20 then fetch it back
    tick();
    we_base = we_cnt;
    data(1'b1, 32'h20, 32'hDEAD_BEEF); #1;
    check("wr_d_gnt",  {31'b0, bus.d_gnt},  32'h1);
    check("wr_mem_we", {31'b0, bus.mem_we}, 32'h1);
    tick();
    idle_inputs();
    fetch(32'h20); #1;
    check("wr_no_d_rvalid", {31'b0, bus.d_rvalid}, 32'h0);
    check("wr_fetch_gnt",   {31'b0, bus.if_gnt},   32'h1);
    check("wr_mem_we_off",  {31'b0, bus.mem_we},   32'h0);
    tick();
    idle_inputs(); #1;
    check("wr_rd_rvalid", {31'b0, bus.if_rvalid}, 32'h1);
    check("wr_rd_rdata",  bus.if_rdata,           32'hDEAD_BEEF);
    tick();
    check("wr_we_pulses", 32'(we_cnt - we_base), 32'h1);

    // misaligned data read
    data(1'b0, 32'h102, 32'h0); #1;
    check("mis_d_gnt",  {31'b0, bus.d_gnt},  32'h1);
    check("mis_mem_en", {31'b0, bus.mem_en}, 32'h0);
    tick();
    idle_inputs(); #1;
    check("mis_no_rvalid", {31'b0, bus.d_rvalid}, 32'h0);
    check("mis_err",       {31'b0, err_misalign}, 32'h1);
    tick();
    check("mis_err_sticky", {31'b0, err_misalign}, 32'h1);

    // high address bits wrap
    fetch(32'h0001_0010); #1;
    check("wrap_addr", 32'(bus.mem_addr), 32'h10);
    tick();
    idle_inputs(); #1;
    check("wrap_rdata", bus.if_rdata, 32'hC800_0000);

    // reset in the cycle after a fetch grant
    tick();
    fetch(32'h10); #1;
    check("rr_if_gnt", {31'b0, bus.if_gnt}, 32'h1);
    tick();
    idle_inputs();
    nreset = 1'b0; #1;
    check("rr_no_rvalid_in_rst", {31'b0, bus.if_rvalid}, 32'h0);
    tick();
    nreset = 1'b1; #1;
    check("rr_no_rvalid_after", {31'b0, bus.if_rvalid}, 32'h0);
    check("rr_err_cleared",     {31'b0, err_misalign},  32'h0);
    check("rr_rdata_cleared",   bus.if_rdata,           32'h0);

    // clk_en low for three cycles mid-read
    tick();
    fetch(32'h20); #1;
    check("ce_if_gnt", {31'b0, bus.if_gnt}, 32'h1);
    tick();
    idle_inputs();
    clk_en = 1'b0;
    data(1'b0, 32'h100, 32'h0); #1;
    for (int i = 0; i < 3; i++) begin
      check("ce_rvalid_frozen", {31'b0, bus.if_rvalid}, 32'h0);
      check("ce_gnt_gated",     {30'b0, bus.if_gnt, bus.d_gnt}, 32'h0);
      check("ce_mem_en_gated",  {31'b0, bus.mem_en}, 32'h0);
      if (i < 2) tick();
    end
    tick();
    idle_inputs();
    clk_en = 1'b1; #1;
    check("ce_rvalid_late", {31'b0, bus.if_rvalid}, 32'h1);
    check("ce_rdata",       bus.if_rdata,           32'hDEAD_BEEF);

    // both ports requesting continuously
    tick();
    for (int k = 0; k < 10; k++) begin
      fetch(32'h10);
      data(1'b0, 32'h100, 32'h0); #1;
`ifdef MEM_ARB_STARVE_GUARD_EN
      exp_gnt = ((k % 5) == 4) ? 2'b10 : 2'b01;
`else
      exp_gnt = 2'b01;
`endif
      check("starve_gnt", {30'b0, bus.if_gnt, bus.d_gnt}, {30'b0, exp_gnt});
      tick();
    end
    idle_inputs();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
